// File: rtl/alu_stage_unit.sv
// -----------------------------------------------------------------------------
// alu_stage_unit
//   Execute-side datapath slice of the multi-cycle CPU: a free-running stage
//   counter, the ALU operand/opcode select and a 32-bit combinational ALU.
//   In the PC-update stage the ALU computes pc+1; in every other stage it
//   applies the decoded operation to the registered register-file reads.
//
// Parameters
//   NUM_STAGES       stage count, counter wraps NUM_STAGES-1 -> 0 (2..8)
//   PC_UPDATE_STAGE  stage index that forces the pc+1 computation
//
// Configuration macro
//   ALU_MUL_EN       when defined, opcode 12 returns low 32 bits of a*b;
//                    otherwise no multiplier exists and opcode 12 yields 0.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_alu_operation  decoded opcode for register-register ops (5 bits)
//   i_reg_value_0    operand A from reg-file read port 0
//   i_reg_value_1    operand B from reg-file read port 1
//   i_pc_value       current program counter
//   o_stage          current stage index
//   o_alu_in0        selected operand A
//   o_alu_in1        selected operand B
//   o_alu_op_select  selected opcode
//   o_alu_result     ALU result
//   o_alu_zero       high when o_alu_result == 0
// -----------------------------------------------------------------------------
module alu_stage_unit #(
  parameter int unsigned NUM_STAGES      = 5,
  parameter int unsigned PC_UPDATE_STAGE = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_alu_operation,
  input  logic [31:0] i_reg_value_0,
  input  logic [31:0] i_reg_value_1,
  input  logic [31:0] i_pc_value,
  output logic [2:0]  o_stage,
  output logic [31:0] o_alu_in0,
  output logic [31:0] o_alu_in1,
  output logic [4:0]  o_alu_op_select,
  output logic [31:0] o_alu_result,
  output logic        o_alu_zero
);

  localparam logic [2:0] LastStage = 3'(NUM_STAGES - 1);
  localparam logic [2:0] PcStage   = 3'(PC_UPDATE_STAGE);

  localparam logic [4:0] OpAdd   = 5'd0;
  localparam logic [4:0] OpSub   = 5'd1;
  localparam logic [4:0] OpAnd   = 5'd2;
  localparam logic [4:0] OpOr    = 5'd3;
  localparam logic [4:0] OpXor   = 5'd4;
  localparam logic [4:0] OpNot   = 5'd5;
  localparam logic [4:0] OpSll   = 5'd6;
  localparam logic [4:0] OpSrl   = 5'd7;
  localparam logic [4:0] OpSra   = 5'd8;
  localparam logic [4:0] OpSlt   = 5'd9;
  localparam logic [4:0] OpSltu  = 5'd10;
  localparam logic [4:0] OpEq    = 5'd11;
  localparam logic [4:0] OpMul   = 5'd12;
  localparam logic [4:0] OpPass0 = 5'd13;
  localparam logic [4:0] OpPass1 = 5'd14;

  logic [2:0]  r_stage;
  logic [2:0]  w_stage_next;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [4:0]  w_op;
  logic [4:0]  w_shamt;
  logic [31:0] w_result;

  // Stage counter: free-running, no stall.
  always_comb begin
    w_stage_next = (r_stage == LastStage) ? 3'd0 : r_stage + 3'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stage <= 3'd0;
    end else begin
      r_stage <= w_stage_next;
    end
  end

  // Operand/opcode select.
  always_comb begin
    if (r_stage == PcStage) begin
      w_a  = i_pc_value;
      w_b  = 32'h1;
      w_op = OpAdd;
    end else begin
      w_a  = i_reg_value_0;
      w_b  = i_reg_value_1;
      w_op = i_alu_operation;
    end
  end

  assign w_shamt = w_b[4:0];

  // Combinational ALU; reserved opcodes return zero.
  always_comb begin
    w_result = 32'h0;
    unique case (w_op)
      OpAdd:   w_result = w_a + w_b;
      OpSub:   w_result = w_a - w_b;
      OpAnd:   w_result = w_a & w_b;
      OpOr:    w_result = w_a | w_b;
      OpXor:   w_result = w_a ^ w_b;
      OpNot:   w_result = ~w_a;
      OpSll:   w_result = w_a << w_shamt;
      OpSrl:   w_result = w_a >> w_shamt;
      OpSra:   w_result = $unsigned($signed(w_a) >>> w_shamt);
      OpSlt:   w_result = {31'h0, $signed(w_a) < $signed(w_b)};
      OpSltu:  w_result = {31'h0, w_a < w_b};
      OpEq:    w_result = {31'h0, w_a == w_b};
`ifdef ALU_MUL_EN
      OpMul:   w_result = w_a * w_b;
`else
      OpMul:   w_result = 32'h0;
`endif
      OpPass0: w_result = w_a;
      OpPass1: w_result = w_b;
      default: w_result = 32'h0;
    endcase
  end

  assign o_stage         = r_stage;
  assign o_alu_in0       = w_a;
  assign o_alu_in1       = w_b;
  assign o_alu_op_select = w_op;
  assign o_alu_result    = w_result;
  assign o_alu_zero      = (w_result == 32'h0);

endmodule

// File: tb/tb_alu_stage_unit.sv
module tb_alu_stage_unit;

  logic        clk;
  logic        rst_n;
  logic [4:0]  alu_operation;
  logic [31:0] reg_value_0;
  logic [31:0] reg_value_1;
  logic [31:0] pc_value;
  logic [2:0]  stage;
  logic [31:0] alu_in0;
  logic [31:0] alu_in1;
  logic [4:0]  alu_op_select;
  logic [31:0] alu_result;
  logic        alu_zero;

  int n_cmp = 0;
  int n_err = 0;

  alu_stage_unit #(
    .NUM_STAGES      (5),
    .PC_UPDATE_STAGE (4)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_alu_operation (alu_operation),
    .i_reg_value_0   (reg_value_0),
    .i_reg_value_1   (reg_value_1),
    .i_pc_value      (pc_value),
    .o_stage         (stage),
    .o_alu_in0       (alu_in0),
    .o_alu_in1       (alu_in1),
    .o_alu_op_select (alu_op_select),
    .o_alu_result    (alu_result),
    .o_alu_zero      (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse reset between edges, then let n rising edges pass; ends 1 after the edge.
  task automatic go_stage(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Register-op vector evaluated in stage 1.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    go_stage(1);
    alu_operation = op;
    reg_value_0   = a;
    reg_value_1   = b;
    #1;
    check_eq({tag, "_stage"}, {29'h0, stage}, 32'd1);
    check_eq(tag, alu_result, exp);
    check_eq({tag, "_zero"}, {31'h0, alu_zero}, {31'h0, exp == 32'h0});
  endtask

  initial begin
    logic [31:0] exp_mul;
    int          seq [6] = '{1, 2, 3, 4, 0, 1};

    rst_n         = 1'b0;
    alu_operation = 5'd0;
    reg_value_0   = 32'h0;
    reg_value_1   = 32'h0;
    pc_value      = 32'h0;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stage", {29'h0, stage}, 32'd0);
    reg_value_0   = 32'd9;
    reg_value_1   = 32'd4;
    alu_operation = 5'd1;
    #1;
    check_eq("rst_select_in0", alu_in0, 32'd9);
    check_eq("rst_select_op", {27'h0, alu_op_select}, 32'd1);
    check_eq("rst_select_res", alu_result, 32'd5);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rel_stage", {29'h0, stage}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("seq_%0d", i), {29'h0, stage}, 32'(seq[i]));
    end

    // Mid-count async reset: stage 1 -> 2 -> 3, then reset between edges.
    repeat (2) @(posedge clk);
    #1;
    check_eq("mid_pre", {29'h0, stage}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst", {29'h0, stage}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("mid_hold", {29'h0, stage}, 32'd0);
    rst_n = 1'b1;

    // PC-update stage.
    go_stage(4);
    pc_value      = 32'd100;
    alu_operation = 5'd1;
    reg_value_0   = 32'd55;
    reg_value_1   = 32'd7;
    #1;
    check_eq("pc_stage", {29'h0, stage}, 32'd4);
    check_eq("pc_in0", alu_in0, 32'd100);
    check_eq("pc_in1", alu_in1, 32'd1);
    check_eq("pc_op", {27'h0, alu_op_select}, 32'd0);
    check_eq("pc_res", alu_result, 32'd101);
    pc_value = 32'hFFFF_FFFF;
    #1;
    check_eq("pc_wrap_res", alu_result, 32'h0);
    check_eq("pc_wrap_zero", {31'h0, alu_zero}, 32'd1);
    @(posedge clk);
    #1;
    check_eq("pc_after_wrap", {29'h0, stage}, 32'd0);
    check_eq("pc_after_in1", alu_in1, 32'd7);

`ifdef ALU_MUL_EN
    exp_mul = 32'd42;
`else
    exp_mul = 32'd0;
`endif

    run_op("add_wrap", 5'd0,  32'hFFFF_FFFF, 32'd1,        32'h0);
    run_op("sub",      5'd1,  32'd3,         32'd5,        32'hFFFF_FFFE);
    run_op("and",      5'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    run_op("or",       5'd3,  32'hF000_0001, 32'h0000_1000, 32'hF000_1001);
    run_op("xor",      5'd4,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
    run_op("not",      5'd5,  32'h0,         32'h1234,     32'hFFFF_FFFF);
    run_op("sll",      5'd6,  32'd1,         32'd31,       32'h8000_0000);
    run_op("srl",      5'd7,  32'h8000_0000, 32'd4,        32'h0800_0000);
    run_op("sra",      5'd8,  32'h8000_0000, 32'd4,        32'hF800_0000);
    run_op("sra_b5",   5'd8,  32'h8000_0000, 32'h24,       32'hF800_0000);
    run_op("slt",      5'd9,  32'hFFFF_FFFF, 32'd1,        32'd1);
    run_op("sltu",     5'd10, 32'hFFFF_FFFF, 32'd1,        32'd0);
    run_op("eq",       5'd11, 32'h1234,      32'h1234,     32'd1);
    run_op("eq_ne",    5'd11, 32'h1234,      32'h1235,     32'd0);
    run_op("mul",      5'd12, 32'd7,         32'd6,        exp_mul);
    run_op("pass0",    5'd13, 32'hDEAD_BEEF, 32'h1,        32'hDEAD_BEEF);
    run_op("pass1",    5'd14, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hCAFE_F00D);
    run_op("rsvd20",   5'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    run_op("rsvd31",   5'd31, 32'd5,         32'd6,        32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
